dmem_mmio_resp: RTL and testbench
=================================

DMEM_MMIO_RESP -- requirements
Module: dmem_mmio_resp

Interface
REQ-001 Parameter AWIDTH, default 12, word-address width; the block covers 2^AWIDTH words.
REQ-002 Parameter MMIO_BASE, default 12'hFF0, first word address of the 16-word MMIO window; addresses below it are RAM.
REQ-003 Parameter INIT_FILE, default "" (empty), hex image loaded into RAM at time zero; empty means RAM contents are unspecified.
REQ-004 CLK  in  1  the only clock; all state updates on the rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 CSN  in  1  chip select, active low.
REQ-007 WEN  in  1  1 = read, 0 = write; sampled only when CSN=0.
REQ-008 ADDR  in  AWIDTH  word address.
REQ-009 BE  in  4  byte enables for writes; BE[i] covers DI[8i+7:8i].
REQ-010 DI  in  32  write data.
REQ-011 DOUT  out  32  registered read data.
REQ-012 OUTPUT_PORT  out  32  value of the MMIO output register.
REQ-013 HALT  out  1  sticky halt flag.
REQ-014 ERR  out  1  sticky flag for an access to a reserved MMIO address.
REQ-015 NUM_WR  out  32  count of accepted write accesses.

Function
REQ-016 Access accepted: CSN=0 and RST=0 and HALT=0 at a rising edge; all other cycles leave RAM, MMIO registers, counters and DOUT unchanged.
REQ-017 RAM write (ADDR<MMIO_BASE): update only the bytes whose BE bit is 1; BE=4'b0000 changes no data but still counts as a write.
REQ-018 RAM read: DOUT = RAM[ADDR] on the edge that accepts the access (1-cycle latency); DOUT holds its value until the next accepted read.
REQ-019 Write at edge N followed by a read of the same address at edge N+1: the read returns the merged new data.
REQ-020 MMIO map (offset from MMIO_BASE): 0 = OUTPUT_PORT (RW, byte-enabled); 1 = HALT_REQ (W: DI[0]=1 with BE[0]=1 sets HALT; R: {31'b0,HALT}); 2 = NUM_WR (RO); 3 = NUM_RD (RO, internal 32-bit read counter); 4..15 = reserved.
REQ-021 Writes to read-only offsets: data is ignored, the access still counts in NUM_WR.
REQ-022 Any access to a reserved offset: ERR=1 from the next cycle, reads return 32'h0, writes are discarded.
REQ-023 NUM_WR increments by 1 per accepted write (RAM or MMIO); NUM_RD increments by 1 per accepted read; both saturate at 32'hFFFFFFFF with no wrap.
REQ-024 Reading NUM_WR/NUM_RD returns the value before the current access's own increment.
REQ-025 HALT rises one cycle after the accepting HALT_REQ write; once HALT=1 the block is frozen: no accesses are accepted, DOUT and all outputs hold.
REQ-026 ERR is sticky; it is cleared only by RST and does not freeze the block.
REQ-027 Out-of-range addresses cannot occur: every ADDR value lies in either RAM or the MMIO window.

Reset
REQ-028 RST=1 at an edge: DOUT=0, OUTPUT_PORT=0, HALT=0, ERR=0, NUM_WR=0, NUM_RD=0; RST takes priority over any access in the same cycle, so that write is dropped.
REQ-029 RAM contents are not affected by RST.
REQ-030 RST asserted while HALT=1 clears the freeze; the access on the first edge with RST=0 is accepted.

Verification
REQ-031 Write 32'hDEADBEEF to 0x010 with BE=1111, then 32'h00AA0000 to 0x010 with BE=0100, then read 0x010 -> DOUT=32'hDEAABEEF one cycle after the read; NUM_WR=2.
REQ-032 Write 32'h5 to 0xFF0 with BE=0001 -> OUTPUT_PORT=32'h00000005 the next cycle; read of 0xFF0 returns 32'h5.
REQ-033 Write DI=1, BE=0001 to 0xFF1, then write 0x020 and read 0x000 -> HALT=1; RAM[0x020], DOUT and NUM_WR are unchanged after HALT.
REQ-034 Read 0xFF7 -> ERR=1 the next cycle, DOUT=0; a following RAM access still completes normally.
REQ-035 Preload NUM_WR to 32'hFFFFFFFE through a forced state or a long write loop, then issue 3 writes -> NUM_WR=32'hFFFFFFFF.
REQ-036 Assert RST in the same cycle as a write of 32'h1234 to 0xFF0, with HALT=1 and ERR=1 beforehand -> OUTPUT_PORT=0, HALT=0, ERR=0, NUM_WR=0 the next cycle.

Source files
------------

// File: rtl/dmem_mmio_if.sv
// Word-addressed memory bus between a requester and dmem_mmio_resp.
// The slave modport is used by the responder; the master modport is for the requester.
interface dmem_mmio_if #(
   parameter int unsigned AWIDTH = 12
);
   logic              CSN;
   logic              WEN;
   logic [AWIDTH-1:0] ADDR;
   logic [3:0]        BE;
   logic [31:0]       DI;
   logic [31:0]       DOUT;
   logic [31:0]       OUTPUT_PORT;
   logic              HALT;
   logic              ERR;
   logic [31:0]       NUM_WR;

   modport master (
      output CSN, WEN, ADDR, BE, DI,
      input  DOUT, OUTPUT_PORT, HALT, ERR, NUM_WR
   );

   modport slave (
      input  CSN, WEN, ADDR, BE, DI,
      output DOUT, OUTPUT_PORT, HALT, ERR, NUM_WR
   );
endinterface

// File: rtl/dmem_mmio_resp.sv
// Single-port data RAM with a 16-word MMIO window (output port, halt request,
// access counters); an accepted halt request freezes the block until reset.
module dmem_mmio_resp #(
   parameter int unsigned AWIDTH    = 12,
   parameter int unsigned MMIO_BASE = 12'hFF0,
   parameter string       INIT_FILE = ""
) (
   input logic          CLK,
   input logic          RST,
   dmem_mmio_if.slave   bus
);
   localparam int unsigned DEPTH    = 32'd1 << AWIDTH;
   localparam logic [3:0]  OFF_OUT  = 4'd0;
   localparam logic [3:0]  OFF_HALT = 4'd1;
   localparam logic [3:0]  OFF_NWR  = 4'd2;
   localparam logic [3:0]  OFF_NRD  = 4'd3;

   logic [31:0] mem [DEPTH];

   logic [31:0] dout_q;
   logic [31:0] out_q;
   logic        halt_q;
   logic        err_q;
   logic [31:0] num_wr_q;
   logic [31:0] num_rd_q;

   logic        accept_c;
   logic        rd_c;
   logic        wr_c;
   logic        is_mmio_c;
   logic        reserved_c;
   logic [3:0]  off_c;
   logic [31:0] mmio_rd_c;

   function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Access decode; a halted block accepts nothing until reset.
   always_comb begin
      accept_c   = !bus.CSN && !RST && !halt_q;
      rd_c       = accept_c && bus.WEN;
      wr_c       = accept_c && !bus.WEN;
      is_mmio_c  = bus.ADDR >= AWIDTH'(MMIO_BASE);
      off_c      = 4'(bus.ADDR - AWIDTH'(MMIO_BASE));
      reserved_c = is_mmio_c && (off_c >= 4'd4);
      mmio_rd_c  = 32'h0;
      case (off_c)
         OFF_OUT:  mmio_rd_c = out_q;
         OFF_HALT: mmio_rd_c = {31'b0, halt_q};
         OFF_NWR:  mmio_rd_c = num_wr_q;
         OFF_NRD:  mmio_rd_c = num_rd_q;
         default:  mmio_rd_c = 32'h0;
      endcase
   end

   // RAM array is not reset so its contents survive RST.
   always_ff @(posedge CLK) begin
      if (wr_c && !is_mmio_c) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.BE[i]) mem[bus.ADDR][8*i +: 8] <= bus.DI[8*i +: 8];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         dout_q   <= 32'h0;
         out_q    <= 32'h0;
         halt_q   <= 1'b0;
         err_q    <= 1'b0;
         num_wr_q <= 32'h0;
         num_rd_q <= 32'h0;
      end else begin
         if (rd_c) begin
            dout_q   <= is_mmio_c ? mmio_rd_c : mem[bus.ADDR];
            num_rd_q <= sat_inc(num_rd_q);
         end
         if (wr_c) begin
            num_wr_q <= sat_inc(num_wr_q);
            if (is_mmio_c && off_c == OFF_OUT) out_q <= be_merge(out_q, bus.DI, bus.BE);
            if (is_mmio_c && off_c == OFF_HALT && bus.BE[0] && bus.DI[0]) halt_q <= 1'b1;
         end
         if (accept_c && reserved_c) err_q <= 1'b1;
      end
   end

   assign bus.DOUT        = dout_q;
   assign bus.OUTPUT_PORT = out_q;
   assign bus.HALT        = halt_q;
   assign bus.ERR         = err_q;
   assign bus.NUM_WR      = num_wr_q;
endmodule

// File: tb/tb_dmem_mmio_resp.sv
// Scoreboard bench for dmem_mmio_resp: a behavioural model predicts every
// cycle's outputs; expected read data is queued at drive time and popped after the edge.
module tb_dmem_mmio_resp;
   localparam int unsigned AW = 12;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   dmem_mmio_if #(.AWIDTH(AW)) bus ();

   dmem_mmio_resp #(
      .AWIDTH   (AW),
      .MMIO_BASE(12'hFF0),
      .INIT_FILE("")
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [31:0] ram_m [int];
   logic [31:0] dout_m = 32'h0;
   logic [31:0] out_m  = 32'h0;
   logic        halt_m = 1'b0;
   logic        err_m  = 1'b0;
   logic [31:0] nwr_m  = 32'h0;
   logic [31:0] nrd_m  = 32'h0;
   logic [31:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] sat(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // One bus cycle: drive at negedge, update the model, compare after the edge.
   task automatic step(input string tag, input bit rst, input bit csn, input bit wen,
                       input logic [11:0] addr, input logic [3:0] be, input logic [31:0] di);
      logic [3:0]  off;
      logic [31:0] v;
      logic [31:0] old;
      @(negedge CLK);
      RST = rst; bus.CSN = csn; bus.WEN = wen; bus.ADDR = addr; bus.BE = be; bus.DI = di;
      off = 4'(addr - 12'hFF0);
      if (rst) begin
         dout_m = 32'h0; out_m = 32'h0; halt_m = 1'b0; err_m = 1'b0;
         nwr_m = 32'h0; nrd_m = 32'h0;
      end else if (!csn && !halt_m) begin
         if (wen) begin
            v = 32'h0;
            if (addr < 12'hFF0) begin
               if (ram_m.exists(int'(addr))) v = ram_m[int'(addr)];
            end else begin
               case (off)
                  4'd0: v = out_m;
                  4'd1: v = {31'b0, halt_m};
                  4'd2: v = nwr_m;
                  4'd3: v = nrd_m;
                  default: begin v = 32'h0; err_m = 1'b1; end
               endcase
            end
            dout_m = v;
            nrd_m  = sat(nrd_m);
         end else begin
            if (addr < 12'hFF0) begin
               old = ram_m.exists(int'(addr)) ? ram_m[int'(addr)] : 32'h0;
               ram_m[int'(addr)] = merge(old, di, be);
            end else begin
               case (off)
                  4'd0: out_m = merge(out_m, di, be);
                  4'd1: if (be[0] && di[0]) halt_m = 1'b1;
                  4'd2, 4'd3: ;
                  default: err_m = 1'b1;
               endcase
            end
            nwr_m = sat(nwr_m);
         end
      end
      exp_q.push_back(dout_m);
      @(posedge CLK);
      #1;
      check({tag, ".dout"}, bus.DOUT, exp_q.pop_front());
      check({tag, ".out"},  bus.OUTPUT_PORT, out_m);
      check({tag, ".halt"}, {31'b0, bus.HALT}, {31'b0, halt_m});
      check({tag, ".err"},  {31'b0, bus.ERR},  {31'b0, err_m});
      check({tag, ".nwr"},  bus.NUM_WR, nwr_m);
   endtask

   task automatic wr(input string tag, input logic [11:0] a, input logic [3:0] be,
                     input logic [31:0] d);
      step(tag, 1'b0, 1'b0, 1'b0, a, be, d);
   endtask

   task automatic rd(input string tag, input logic [11:0] a);
      step(tag, 1'b0, 1'b0, 1'b1, a, 4'h0, 32'h0);
   endtask

   initial begin
      logic [31:0] d;
      logic [3:0]  b;

      step("rst0", 1'b1, 1'b1, 1'b1, 12'h000, 4'h0, 32'h0);
      step("rst1", 1'b1, 1'b0, 1'b0, 12'hFF0, 4'hF, 32'hFFFF_FFFF);
      check("rst.dout", bus.DOUT, 32'h0);
      check("rst.nwr",  bus.NUM_WR, 32'h0);

      // Byte-merged RAM write followed immediately by a read.
      wr("w010a", 12'h010, 4'b1111, 32'hDEAD_BEEF);
      wr("w010b", 12'h010, 4'b0100, 32'h00AA_0000);
      rd("r010",  12'h010);
      check("merge.dout", bus.DOUT, 32'hDEAA_BEEF);
      check("merge.nwr",  bus.NUM_WR, 32'd2);

      wr("w011a", 12'h011, 4'b1111, 32'hA5A5_A5A5);
      wr("w011z", 12'h011, 4'b0000, 32'hFFFF_FFFF);
      rd("r011",  12'h011);
      check("be0.dout", bus.DOUT, 32'hA5A5_A5A5);

      wr("wout", 12'hFF0, 4'b0001, 32'h0000_0005);
      check("outport", bus.OUTPUT_PORT, 32'h5);
      rd("rout", 12'hFF0);
      check("rout.dout", bus.DOUT, 32'h5);

      step("nocs", 1'b0, 1'b1, 1'b0, 12'h010, 4'hF, 32'h0);
      rd("rnwr",  12'hFF2);
      check("rnwr.dout", bus.DOUT, 32'd5);
      rd("rnrd",  12'hFF3);
      rd("rhalt", 12'hFF1);
      wr("wro",   12'hFF2, 4'hF, 32'h1234_5678);

      // Reserved offset: error flag, zero data, block keeps running.
      rd("rres", 12'hFF7);
      check("rres.err",  {31'b0, bus.ERR}, 32'd1);
      check("rres.dout", bus.DOUT, 32'h0);
      rd("r010b", 12'h010);
      check("after_err.dout", bus.DOUT, 32'hDEAA_BEEF);
      wr("wres", 12'hFFA, 4'hF, 32'hCAFE_F00D);

      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         b = 4'($urandom_range(0, 15));
         wr("lpfull", 12'(12'h100 + i), 4'hF, 32'h0101_0101 * (i + 1));
         wr("lpbe",   12'(12'h100 + i), b, d);
         rd("lprd",   12'(12'h100 + i));
      end

      // Halt request freezes the block.
      wr("w020", 12'h020, 4'hF, 32'h1111_2222);
      wr("whalt", 12'hFF1, 4'b0001, 32'h1);
      check("halt", {31'b0, bus.HALT}, 32'd1);
      wr("w020h", 12'h020, 4'hF, 32'h3333_4444);
      rd("r000h", 12'h000);
      wr("wouth", 12'hFF0, 4'hF, 32'h9999_9999);

      // Reset beats the simultaneous write and clears halt/err.
      step("rstw", 1'b1, 1'b0, 1'b0, 12'hFF0, 4'hF, 32'h0000_1234);
      check("rstw.out",  bus.OUTPUT_PORT, 32'h0);
      check("rstw.halt", {31'b0, bus.HALT}, 32'h0);
      check("rstw.err",  {31'b0, bus.ERR}, 32'h0);
      check("rstw.nwr",  bus.NUM_WR, 32'h0);
      rd("r020", 12'h020);
      check("ram_kept", bus.DOUT, 32'h1111_2222);

      // Counter saturation from a forced near-full value.
      @(negedge CLK);
      bus.CSN = 1'b1;
      force dut.num_wr_q = 32'hFFFF_FFFE;
      #1;
      release dut.num_wr_q;
      nwr_m = 32'hFFFF_FFFE;
      wr("sat0", 12'h030, 4'hF, 32'h1);
      wr("sat1", 12'h031, 4'hF, 32'h2);
      wr("sat2", 12'h032, 4'hF, 32'h3);
      check("sat.nwr", bus.NUM_WR, 32'hFFFF_FFFF);
      rd("rsat", 12'hFF2);
      check("rsat.dout", bus.DOUT, 32'hFFFF_FFFF);

      step("idle", 1'b0, 1'b1, 1'b1, 12'h000, 4'h0, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
